// File: rtl/rowwise_reduce_pkg.sv
// Shared fixed-point types and constants for the rowwise reduction unit.
// The rowwise units also reuse FP_MIN and FP_MAX for their saturation bounds.
package rowwise_reduce_pkg;

  localparam int FP_W      = 16;
  localparam int FRAC_BITS = 8;
  localparam int D         = 8;
  localparam int ACC_W     = FP_W + $clog2(D) + 1;

  typedef logic signed [FP_W-1:0] fixed_point_t;
  typedef logic [$clog2(D)-1:0]   DI_t;

  typedef enum logic [1:0] {
    RED_SUM   = 2'd0,
    RED_MAX   = 2'd1,
    RED_SUMSQ = 2'd2
  } reduce_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } red_state_t;

  localparam fixed_point_t FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
  localparam fixed_point_t FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

endpackage

// File: rtl/rowwise_reduce_step.sv
// One reduction step: folds element x into the accumulator for the given op.
// Sums saturate at the signed ACC_W limits; sat flags when that clipping happens.
module rowwise_reduce_step
  import rowwise_reduce_pkg::*;
#(
  parameter int AW = ACC_W
) (
  input  logic signed [AW-1:0] acc,
  input  fixed_point_t         x,
  input  reduce_op_t           op,
  output logic signed [AW-1:0] next_acc,
  output logic                 sat
);

  // Working width holds acc plus the largest possible square without wrapping.
  localparam int SW = 2*FP_W + 2;
  localparam logic signed [SW-1:0] LIM_MAX = $signed({{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}});
  localparam logic signed [SW-1:0] LIM_MIN = $signed({{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}});

  logic signed [2*FP_W-1:0] x_p;
  logic signed [2*FP_W-1:0] prod;
  logic signed [2*FP_W-1:0] sq_sh;
  logic signed [SW-1:0]     acc_w;
  logic signed [SW-1:0]     x_w;
  logic signed [SW-1:0]     sum_w;

  always_comb begin
    x_p      = (2*FP_W)'(x);
    prod     = x_p * x_p;
    sq_sh    = prod >>> FRAC_BITS;
    acc_w    = SW'(acc);
    x_w      = SW'(x);
    sum_w    = acc_w;
    next_acc = acc;
    sat      = 1'b0;
    case (op)
      RED_MAX: begin
        if (x_w > acc_w) next_acc = AW'(x_w);
      end
      RED_SUMSQ: sum_w = acc_w + SW'(sq_sh);
      default:   sum_w = acc_w + x_w;
    endcase
    if (op != RED_MAX) begin
      if (sum_w > LIM_MAX) begin
        next_acc = AW'(LIM_MAX);
        sat      = 1'b1;
      end else if (sum_w < LIM_MIN) begin
        next_acc = AW'(LIM_MIN);
        sat      = 1'b1;
      end else begin
        next_acc = AW'(sum_w);
      end
    end
  end

endmodule

// File: rtl/rowwise_reduce.sv
// Reduces N_ELEM scratchpad elements (one per cycle) to a saturated scalar
// via SUM, MAX or SUMSQ, then holds it until the consumer takes it.
module rowwise_reduce
  import rowwise_reduce_pkg::*;
#(
  parameter int N_ELEM = D
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  reduce_op_t   reduce_op_i,
  output DI_t          vector_addr_o,
  input  fixed_point_t vector_r_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output fixed_point_t result_o,
  output logic         overflow_o,
  output red_state_t   dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are
  // both high; valid holds its payload until then and never waits on ready.
  localparam logic signed [ACC_W-1:0] ACC_FP_MAX = ACC_W'(FP_MAX);
  localparam logic signed [ACC_W-1:0] ACC_FP_MIN = ACC_W'(FP_MIN);

  red_state_t              state_q, state_d;
  DI_t                     count_q;
  logic signed [ACC_W-1:0] acc_q;
  reduce_op_t              op_q;
  logic                    acc_sat_q;
  logic signed [ACC_W-1:0] step_acc;
  logic                    step_sat;
  logic                    accept;
  logic                    clip_hi;
  logic                    clip_lo;

  rowwise_reduce_step #(.AW(ACC_W)) u_step (
    .acc      (acc_q),
    .x        (vector_r_data_i),
    .op       (op_q),
    .next_acc (step_acc),
    .sat      (step_sat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    vector_addr_o = '0;
    accept        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        accept     = in_valid_i;
        if (in_valid_i) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        vector_addr_o = count_q;
        if (count_q == DI_t'(N_ELEM-1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= '0;
      acc_q     <= '0;
      op_q      <= RED_SUM;
      acc_sat_q <= 1'b0;
    end else if (accept) begin
      count_q   <= '0;
      acc_sat_q <= 1'b0;
      // Encodings outside the enum fall back to SUM.
      case (reduce_op_i)
        RED_MAX: begin
          op_q  <= RED_MAX;
          acc_q <= ACC_FP_MIN;
        end
        RED_SUMSQ: begin
          op_q  <= RED_SUMSQ;
          acc_q <= '0;
        end
        default: begin
          op_q  <= RED_SUM;
          acc_q <= '0;
        end
      endcase
    end else if (state_q == ST_ACCUM) begin
      acc_q     <= step_acc;
      acc_sat_q <= acc_sat_q | step_sat;
      count_q   <= count_q + DI_t'(1);
    end
  end

  always_comb begin
    clip_hi    = acc_q > ACC_FP_MAX;
    clip_lo    = acc_q < ACC_FP_MIN;
    result_o   = '0;
    overflow_o = 1'b0;
    if (state_q == ST_DONE) begin
      if (clip_hi)      result_o = FP_MAX;
      else if (clip_lo) result_o = FP_MIN;
      else              result_o = acc_q[FP_W-1:0];
      overflow_o = acc_sat_q | clip_hi | clip_lo;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rowwise_reduce.sv
// Directed bench for rowwise_reduce: scratchpad model, command driver, hand-computed results.
module tb_rowwise_reduce;
  import rowwise_reduce_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  reduce_op_t   red_op = RED_SUM;
  DI_t          vaddr;
  fixed_point_t rdata;
  logic         out_valid;
  logic         out_ready = 1'b0;
  fixed_point_t result;
  logic         overflow;
  red_state_t   dbg_state;

  fixed_point_t mem [D];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rdata = mem[vaddr];

  rowwise_reduce dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .reduce_op_i     (red_op),
    .vector_addr_o   (vaddr),
    .vector_r_data_i (rdata),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .result_o        (result),
    .overflow_o      (overflow),
    .dbg_state_o     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input fixed_point_t v);
    for (int i = 0; i < D; i++) mem[i] = v;
  endtask

  // Issues one command and checks latency, result, hold behaviour and return to IDLE.
  task automatic run_cmd(input string tag, input reduce_op_t op, input fixed_point_t exp_res,
                         input logic exp_ovf, input int hold);
    int lat;
    logic stable;
    @(posedge clk); #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    red_op   = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    red_op   = RED_SUM;
    check({tag, "_accum"}, 32'(dbg_state), 32'(ST_ACCUM));
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(D));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_addr_done"}, 32'(vaddr), 32'd0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || result !== exp_res || overflow !== exp_ovf) stable = 1'b0;
      end
      check({tag, "_hold_stable"}, 32'(stable), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int guard;
    fill(16'sd0);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: SUM of ones
    fill(16'sd1);
    run_cmd("sum_ones", RED_SUM, 16'sd8, 1'b0, 0);

    // 2: MAX of mixed values
    fill(-16'sd100);
    mem[0] = -16'sd5; mem[1] = 16'sd3; mem[2] = -16'sd7; mem[3] = 16'sd3; mem[4] = 16'sd0;
    run_cmd("max_mixed", RED_MAX, 16'sd3, 1'b0, 0);

    // 3: MAX of all FP_MIN
    fill(FP_MIN);
    run_cmd("max_min", RED_MAX, FP_MIN, 1'b0, 0);

    // 4: SUM of all FP_MAX clips at output
    fill(FP_MAX);
    run_cmd("sum_max", RED_SUM, FP_MAX, 1'b1, 0);

    // SUM of all FP_MIN clips low
    fill(FP_MIN);
    run_cmd("sum_min", RED_SUM, FP_MIN, 1'b1, 0);

    // SUMSQ of all FP_MIN: 2^22 per element saturates the accumulator
    run_cmd("sumsq_sat", RED_SUMSQ, FP_MAX, 1'b1, 0);

    // 5: SUMSQ of a single 2.0
    fill(16'sd0);
    mem[0] = 16'sd512;
    run_cmd("sumsq_two", RED_SUMSQ, 16'sd1024, 1'b0, 0);

    // Undefined op encoding behaves as SUM: 8 * 2
    fill(16'sd2);
    run_cmd("undef_op", reduce_op_t'(2'd3), 16'sd16, 1'b0, 0);

    // 6: consumer stalls 10 cycles, then a second command
    fill(-16'sd3);
    run_cmd("hold", RED_SUM, -16'sd24, 1'b0, 10);
    mem[6] = 16'sd9;
    run_cmd("after_hold", RED_MAX, 16'sd9, 1'b0, 0);

    // 7: reset mid-ACCUM at count D/2
    fill(16'sd50);
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (vaddr != DI_t'(D/2) && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_reach_mid", 32'(vaddr), 32'(D/2));
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_addr", 32'(vaddr), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = fixed_point_t'(i);
    run_cmd("post_abort", RED_SUM, 16'sd28, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
